// File: rtl/sram_banked_obi.sv
// rtl/sram_banked_obi.sv - dual-port OBI SRAM controller over NUM_BANKS 1rw1r macros
// Ports: clk_i/rst_i (sync, active high); D port d_req_i/d_gnt_o/d_addr_i/d_we_i/d_be_i/d_wdata_i ->
//   d_rvalid_o/d_rdata_o/d_err_o; I port likewise with i_ prefix; init_done_o (fill complete);
//   err_count_o (saturating error response count, both ports).
module sram_banked_obi #(
  parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
  parameter int          NUM_BANKS     = 12,
  parameter int          BANK_WORDS    = 512,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        d_req_i,
  output logic        d_gnt_o,
  input  logic [31:0] d_addr_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  input  logic        i_req_i,
  output logic        i_gnt_o,
  input  logic [31:0] i_addr_i,
  input  logic        i_we_i,
  input  logic [3:0]  i_be_i,
  input  logic [31:0] i_wdata_i,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  output logic        i_err_o,
  output logic        init_done_o,
  output logic [15:0] err_count_o
);

  localparam int          WORD_BITS = $clog2(BANK_WORDS);
  localparam int          BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDR} + 33'(NUM_BANKS * BANK_WORDS * 4);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e                 state_q, state_d;
  logic [WORD_BITS-1:0]   cnt_q, cnt_d;

  // Macro array: port 0 is rw, port 1 is read-only; read data is registered per bank.
  logic [31:0]            mem_q   [NUM_BANKS][BANK_WORDS];
  logic [31:0]            dout0_q [NUM_BANKS];
  logic [31:0]            dout1_q [NUM_BANKS];

  logic [NUM_BANKS-1:0]   cs0, cs1;
  logic                   we0;
  logic [WORD_BITS-1:0]   addr0, addr1;
  logic [31:0]            din0;
  logic [3:0]             mask0;

  logic                   d_in, i_in, hazard, d_gnt, i_gnt;
  logic [BANK_BITS-1:0]   d_bank, i_bank;
  logic [WORD_BITS-1:0]   d_word, i_word;
  logic [16:0]            err_sum;

  logic                   d_rvalid_q, d_err_q, d_rd_q;
  logic                   i_rvalid_q, i_err_q, i_rd_q;
  logic [BANK_BITS-1:0]   d_bank_q, i_bank_q;
  logic [15:0]            err_cnt_q, err_cnt_d;

  always_comb begin
    d_in   = ({1'b0, d_addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, d_addr_i} < END_ADDR);
    i_in   = ({1'b0, i_addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, i_addr_i} < END_ADDR);
    d_bank = BANK_BITS'((d_addr_i - BASE_ADDR) >> (WORD_BITS + 2));
    i_bank = BANK_BITS'((i_addr_i - BASE_ADDR) >> (WORD_BITS + 2));
    d_word = WORD_BITS'((d_addr_i - BASE_ADDR) >> 2);
    i_word = WORD_BITS'((i_addr_i - BASE_ADDR) >> 2);
    // A macro read on port 1 of the word port 0 is writing returns stale data, so I waits.
    hazard = d_req_i && d_we_i && d_in && i_in && (d_bank == i_bank) && (d_word == i_word);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_gnt   = 1'b0;
    i_gnt   = 1'b0;
    cs0     = '0;
    cs1     = '0;
    we0     = 1'b0;
    addr0   = '0;
    addr1   = '0;
    din0    = '0;
    mask0   = '0;
    case (state_q)
      ST_INIT: begin
        cs0   = '1;
        we0   = 1'b1;
        addr0 = cnt_q;
        mask0 = 4'hF;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == WORD_BITS'(BANK_WORDS - 1)) state_d = ST_READY;
      end
      default: begin
        d_gnt = d_req_i;
        // I writes share port 0 with D, which always wins.
        i_gnt = i_we_i ? (i_req_i && !d_req_i) : (i_req_i && !hazard);
        if (d_gnt && d_in) begin
          for (int b = 0; b < NUM_BANKS; b++) cs0[b] = (d_bank == BANK_BITS'(b));
          we0   = d_we_i;
          addr0 = d_word;
          din0  = d_wdata_i;
          mask0 = d_be_i;
        end else if (i_gnt && i_we_i && i_in) begin
          for (int b = 0; b < NUM_BANKS; b++) cs0[b] = (i_bank == BANK_BITS'(b));
          we0   = 1'b1;
          addr0 = i_word;
          din0  = i_wdata_i;
          mask0 = i_be_i;
        end
        if (i_gnt && !i_we_i && i_in) begin
          for (int b = 0; b < NUM_BANKS; b++) cs1[b] = (i_bank == BANK_BITS'(b));
          addr1 = i_word;
        end
      end
    endcase
    if (rst_i) begin
      d_gnt = 1'b0;
      i_gnt = 1'b0;
      cs0   = '0;
      cs1   = '0;
    end
  end

  always_comb begin
    err_sum   = {1'b0, err_cnt_q} + 17'(d_gnt && !d_in) + 17'(i_gnt && !i_in);
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= INIT_ON_RESET ? ST_INIT : ST_READY;
      cnt_q      <= '0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_rd_q     <= 1'b0;
      d_bank_q   <= '0;
      i_rvalid_q <= 1'b0;
      i_err_q    <= 1'b0;
      i_rd_q     <= 1'b0;
      i_bank_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_rvalid_q <= d_gnt;
      d_err_q    <= d_gnt && !d_in;
      d_rd_q     <= d_gnt && d_in && !d_we_i;
      d_bank_q   <= d_bank;
      i_rvalid_q <= i_gnt;
      i_err_q    <= i_gnt && !i_in;
      i_rd_q     <= i_gnt && i_in && !i_we_i;
      i_bank_q   <= i_bank;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (cs0[b]) begin
        if (we0) begin
          for (int k = 0; k < 4; k++)
            if (mask0[k]) mem_q[b][addr0][8*k +: 8] <= din0[8*k +: 8];
        end else begin
          dout0_q[b] <= mem_q[b][addr0];
        end
      end
      if (cs1[b]) dout1_q[b] <= mem_q[b][addr1];
    end
  end

  assign d_gnt_o     = d_gnt;
  assign i_gnt_o     = i_gnt;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_err_o     = d_err_q;
  assign d_rdata_o   = d_rd_q ? dout0_q[d_bank_q] : 32'h0;
  assign i_rvalid_o  = i_rvalid_q;
  assign i_err_o     = i_err_q;
  assign i_rdata_o   = i_rd_q ? dout1_q[i_bank_q] : 32'h0;
  assign init_done_o = (state_q == ST_READY) && !rst_i;
  assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_sram_banked_obi.sv
// tb/tb_sram_banked_obi.sv - directed vector bench for sram_banked_obi
module tb_sram_banked_obi;

  logic        clk, rst;
  logic        d_req, d_gnt, d_we, d_rvalid, d_err;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        i_req, i_gnt, i_we, i_rvalid, i_err;
  logic [3:0]  i_be;
  logic [31:0] i_addr, i_wdata, i_rdata;
  logic        init_done;
  logic [15:0] err_count;

  int tests = 0;
  int fails = 0;

  sram_banked_obi dut (
    .clk_i(clk), .rst_i(rst),
    .d_req_i(d_req), .d_gnt_o(d_gnt), .d_addr_i(d_addr), .d_we_i(d_we), .d_be_i(d_be),
    .d_wdata_i(d_wdata), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata), .d_err_o(d_err),
    .i_req_i(i_req), .i_gnt_o(i_gnt), .i_addr_i(i_addr), .i_we_i(i_we), .i_be_i(i_be),
    .i_wdata_i(i_wdata), .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata), .i_err_o(i_err),
    .init_done_o(init_done), .err_count_o(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        i_req, i_we;
    logic [3:0]  i_be;
    logic [31:0] i_addr, i_wdata;
    logic        e_dgnt, e_ignt, e_drv;
    logic [31:0] e_drdata;
    logic        e_derr, e_irv;
    logic [31:0] e_irdata;
    logic        e_ierr;
    logic [15:0] e_errcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic dr, input logic dw, input logic [3:0] db, input logic [31:0] da, input logic [31:0] dd,
    input logic ir, input logic iw, input logic [3:0] ib, input logic [31:0] ia, input logic [31:0] id,
    input logic edg, input logic eig, input logic edv, input logic [31:0] edd, input logic ede,
    input logic eiv, input logic [31:0] eid, input logic eie, input logic [15:0] ec);
    vec_t v;
    v.d_req = dr; v.d_we = dw; v.d_be = db; v.d_addr = da; v.d_wdata = dd;
    v.i_req = ir; v.i_we = iw; v.i_be = ib; v.i_addr = ia; v.i_wdata = id;
    v.e_dgnt = edg; v.e_ignt = eig; v.e_drv = edv; v.e_drdata = edd; v.e_derr = ede;
    v.e_irv = eiv; v.e_irdata = eid; v.e_ierr = eie; v.e_errcnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    i_req = 0; i_we = 0; i_be = 0; i_addr = 0; i_wdata = 0;
  endtask

  // One-cycle transfer: drive at negedge, check grants, check responses just after the edge.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    d_req = v.d_req; d_we = v.d_we; d_be = v.d_be; d_addr = v.d_addr; d_wdata = v.d_wdata;
    i_req = v.i_req; i_we = v.i_we; i_be = v.i_be; i_addr = v.i_addr; i_wdata = v.i_wdata;
    #1;
    check({tag, " d_gnt"}, 32'(d_gnt), 32'(v.e_dgnt));
    check({tag, " i_gnt"}, 32'(i_gnt), 32'(v.e_ignt));
    @(posedge clk);
    #1;
    idle_inputs();
    check({tag, " d_rvalid"}, 32'(d_rvalid), 32'(v.e_drv));
    check({tag, " d_rdata"}, d_rdata, v.e_drdata);
    check({tag, " d_err"}, 32'(d_err), 32'(v.e_derr));
    check({tag, " i_rvalid"}, 32'(i_rvalid), 32'(v.e_irv));
    check({tag, " i_rdata"}, i_rdata, v.e_irdata);
    check({tag, " i_err"}, 32'(i_err), 32'(v.e_ierr));
    check({tag, " err_count"}, 32'(err_count), 32'(v.e_errcnt));
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (init_done) break;
    end
  endtask

  int n;

  initial begin
    idle_inputs();
    rst = 1;

    //        D: req we be   addr           wdata         I: req we be   addr           wdata         exp: dg ig drv drdata        derr irv irdata        ierr cnt
    vecs.push_back(mk(1, 0, 4'hF, 32'h8000_5FFC, 32'h0,        0, 0, 4'h0, 32'h0,         32'h0,        1, 0, 1, 32'h0,        0, 0, 32'h0,        0, 0));
    vecs.push_back(mk(1, 1, 4'h3, 32'h8000_0804, 32'hDEADBEEF, 0, 0, 4'h0, 32'h0,         32'h0,        1, 0, 1, 32'h0,        0, 0, 32'h0,        0, 0));
    vecs.push_back(mk(1, 0, 4'hF, 32'h8000_0804, 32'h0,        0, 0, 4'h0, 32'h0,         32'h0,        1, 0, 1, 32'h0000BEEF, 0, 0, 32'h0,        0, 0));
    vecs.push_back(mk(1, 1, 4'hC, 32'h8000_0804, 32'hA5A5A5A5, 0, 0, 4'h0, 32'h0,         32'h0,        1, 0, 1, 32'h0,        0, 0, 32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 32'h0,         32'h0,        1, 0, 4'hF, 32'h8000_0804, 32'h0,        0, 1, 0, 32'h0,        0, 1, 32'hA5A5BEEF, 0, 0));
    vecs.push_back(mk(1, 1, 4'hF, 32'h8000_5FFC, 32'h11223344, 1, 0, 4'hF, 32'h8000_0804, 32'h0,        1, 1, 1, 32'h0,        0, 1, 32'hA5A5BEEF, 0, 0));
    vecs.push_back(mk(1, 0, 4'hF, 32'h8000_5FFC, 32'h0,        1, 0, 4'hF, 32'h8000_5FFC, 32'h0,        1, 1, 1, 32'h11223344, 0, 1, 32'h11223344, 0, 0));
    vecs.push_back(mk(1, 0, 4'hF, 32'h8000_0804, 32'h0,        1, 1, 4'hF, 32'h8000_1000, 32'h12345678, 1, 0, 1, 32'hA5A5BEEF, 0, 0, 32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 32'h0,         32'h0,        1, 1, 4'hF, 32'h8000_1000, 32'h12345678, 0, 1, 0, 32'h0,        0, 1, 32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 32'h0,         32'h0,        1, 0, 4'hF, 32'h8000_1000, 32'h0,        0, 1, 0, 32'h0,        0, 1, 32'h12345678, 0, 0));
    vecs.push_back(mk(1, 1, 4'hF, 32'h8000_0010, 32'hCAFEF00D, 1, 0, 4'hF, 32'h8000_0010, 32'h0,        1, 0, 1, 32'h0,        0, 0, 32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 32'h0,         32'h0,        1, 0, 4'hF, 32'h8000_0010, 32'h0,        0, 1, 0, 32'h0,        0, 1, 32'hCAFEF00D, 0, 0));
    vecs.push_back(mk(1, 0, 4'hF, 32'h8000_6000, 32'h0,        1, 0, 4'hF, 32'h7FFF_FFFC, 32'h0,        1, 1, 1, 32'h0,        1, 1, 32'h0,        1, 2));
    vecs.push_back(mk(1, 1, 4'hF, 32'h9000_0000, 32'hFFFFFFFF, 0, 0, 4'h0, 32'h0,         32'h0,        1, 0, 1, 32'h0,        1, 0, 32'h0,        0, 3));
    vecs.push_back(mk(1, 0, 4'hF, 32'h8000_5FFF, 32'h0,        0, 0, 4'h0, 32'h0,         32'h0,        1, 0, 1, 32'h11223344, 0, 0, 32'h0,        0, 3));
    vecs.push_back(mk(1, 1, 4'h4, 32'h8000_0010, 32'h00770000, 0, 0, 4'h0, 32'h0,         32'h0,        1, 0, 1, 32'h0,        0, 0, 32'h0,        0, 3));
    vecs.push_back(mk(1, 0, 4'hF, 32'h8000_0010, 32'h0,        0, 0, 4'h0, 32'h0,         32'h0,        1, 0, 1, 32'hCA77F00D, 0, 0, 32'h0,        0, 3));
    vecs.push_back(mk(1, 0, 4'hF, 32'h8000_1000, 32'h0,        1, 0, 4'hF, 32'h8000_1000, 32'h0,        1, 1, 1, 32'h12345678, 0, 1, 32'h12345678, 0, 3));
    vecs.push_back(mk(0, 0, 4'h0, 32'h0,         32'h0,        1, 1, 4'hF, 32'h7000_0000, 32'h0000DEAD, 0, 1, 0, 32'h0,        0, 1, 32'h0,        1, 4));
    vecs.push_back(mk(1, 1, 4'hF, 32'h8000_0014, 32'h00000077, 1, 0, 4'hF, 32'h8000_0010, 32'h0,        1, 1, 1, 32'h0,        0, 1, 32'hCA77F00D, 0, 4));

    repeat (3) @(posedge clk);
    @(negedge clk);
    d_req = 1; i_req = 1; d_addr = 32'h8000_0000; i_addr = 32'h8000_0000;
    #1;
    check("reset d_gnt", 32'(d_gnt), 32'h0);
    check("reset i_gnt", 32'(i_gnt), 32'h0);
    check("reset d_rvalid", 32'(d_rvalid), 32'h0);
    check("reset i_rvalid", 32'(i_rvalid), 32'h0);
    check("reset init_done", 32'(init_done), 32'h0);
    check("reset err_count", 32'(err_count), 32'h0);

    // First cycle of the fill: requests must still be held off.
    @(negedge clk);
    rst = 0;
    #1;
    check("init d_gnt", 32'(d_gnt), 32'h0);
    check("init i_gnt", 32'(i_gnt), 32'h0);
    idle_inputs();
    wait_init(n);
    check("init cycles", 32'(n), 32'd512);

    for (int k = 0; k < vecs.size(); k++) apply(vecs[k], $sformatf("v%0d", k));

    // Response lasts exactly one cycle.
    @(negedge clk);
    d_req = 1; d_addr = 32'h8000_1000;
    @(posedge clk);
    #1;
    idle_inputs();
    check("hold rvalid t1", 32'(d_rvalid), 32'h1);
    check("hold rdata t1", d_rdata, 32'h12345678);
    @(posedge clk);
    #1;
    check("hold rvalid t2", 32'(d_rvalid), 32'h0);
    check("hold rdata t2", d_rdata, 32'h0);

    // Plant data, then interrupt a fill at word 200 and make sure it starts over.
    apply(mk(1, 1, 4'hF, 32'h8000_04B0, 32'h5555AAAA, 0, 0, 4'h0, 32'h0, 32'h0,
             1, 0, 1, 32'h0, 0, 0, 32'h0, 0, 4), "plant");
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (200) @(posedge clk);
    #1;
    check("midfill init_done", 32'(init_done), 32'h0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    wait_init(n);
    check("refill cycles", 32'(n), 32'd512);
    apply(mk(1, 0, 4'hF, 32'h8000_04B0, 32'h0, 1, 0, 4'hF, 32'h8000_0804, 32'h0,
             1, 1, 1, 32'h0, 0, 1, 32'h0, 0, 0), "after refill");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
